dmem_port_arbiter: RTL and testbench

- Shares the single-port 256-word data memory between two requesters: the pipeline MEM stage (port A, normally high priority) and the program-loader/debug port (port B).
- Issues at most one access per cycle and returns read data one cycle after grant.
- Stalls the pipeline while port A is waiting.
- A starvation counter guarantees port B forward progress.
- Sits between the MEM stage and the data memory instance.

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_port_arbiter_if.sv | 49 ++++
 rtl/dmem_starve_counter.sv | 31 +++
 rtl/dmem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter and its helpers.
package dmem_pkg;

  localparam int unsigned DMEM_ADDR_W = 8;
  localparam int unsigned DMEM_DATA_W = 32;
  localparam int unsigned DMEM_WAIT_W = 4;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    RESP_A = 2'd1,
    RESP_B = 2'd2
  } resp_owner_t;

  localparam logic [1:0] PORT_SEL_NONE = 2'd0;
  localparam logic [1:0] PORT_SEL_A    = 2'd1;
  localparam logic [1:0] PORT_SEL_B    = 2'd2;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port data memory.
interface dmem_port_arbiter_if
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = DMEM_ADDR_W,
  parameter int unsigned DATA_W = DMEM_DATA_W
);

  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_stall;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_stall, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_stall, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_starve_counter.sv
// Saturating wait counter: counts refused cycles, flags when the limit is reached.
module dmem_starve_counter
  import dmem_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clear,
  output logic o_at_max_c
);

  localparam logic [DMEM_WAIT_W-1:0] MAX_CNT = DMEM_WAIT_W'(MAX_WAIT);

  logic [DMEM_WAIT_W-1:0] r_cnt;

  // Clear has priority over increment; holds at the limit until cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX_CNT)) begin
      r_cnt <= r_cnt + DMEM_WAIT_W'(1);
    end
  end

  assign o_at_max_c = (r_cnt == MAX_CNT);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the single-port data memory (A = MEM stage, B = loader/debug).
// Optional performance counters are enabled with `define DMEM_ARB_PERF_EN.
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W   = DMEM_ADDR_W,
  parameter int unsigned DATA_W   = DMEM_DATA_W,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  dmem_port_arbiter_if.slave bus
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_starve_cnt
`endif
);

  logic              w_at_max;
  logic              w_a_win;
  logic              w_b_win;
  logic [1:0]        w_sel;
  logic              w_win_we;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;
  logic              w_a_stall;

  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  resp_owner_t       r_resp_owner;
  resp_owner_t       w_resp_owner_nxt;

  dmem_starve_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk        (clk),
    .rst        (rst),
    .i_inc      (bus.b_req & ~w_b_win),
    .i_clear    (~bus.b_req | w_b_win),
    .o_at_max_c (w_at_max)
  );

  // B wins when A is idle or B has waited its limit; nothing is granted in reset.
  always_comb begin
    w_a_win = 1'b0;
    w_b_win = 1'b0;
    w_sel   = PORT_SEL_NONE;
    if (!rst) begin
      if (bus.b_req && (!bus.a_req || w_at_max)) begin
        w_b_win = 1'b1;
        w_sel   = PORT_SEL_B;
      end else if (bus.a_req) begin
        w_a_win = 1'b1;
        w_sel   = PORT_SEL_A;
      end
    end
  end

  // Memory drive follows the winner; address/data hold their last value when idle.
  always_comb begin
    w_win_addr  = r_mem_addr;
    w_win_wdata = r_mem_wdata;
    w_win_we    = 1'b0;
    case (w_sel)
      PORT_SEL_A: begin
        w_win_addr  = bus.a_addr;
        w_win_wdata = bus.a_wdata;
        w_win_we    = bus.a_we;
      end
      PORT_SEL_B: begin
        w_win_addr  = bus.b_addr;
        w_win_wdata = bus.b_wdata;
        w_win_we    = bus.b_we;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_sel != PORT_SEL_NONE) begin
      r_mem_addr  <= w_win_addr;
      r_mem_wdata <= w_win_wdata;
    end
  end

  assign w_a_stall     = bus.a_req & ~w_a_win;
  assign bus.a_gnt     = w_a_win;
  assign bus.b_gnt     = w_b_win;
  assign bus.a_stall   = w_a_stall;
  assign bus.mem_addr  = w_win_addr;
  assign bus.mem_wdata = w_win_wdata;
  assign bus.mem_we    = w_win_we;

  // Read-response owner: one cycle after a granted read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_owner <= NONE;
    end else begin
      r_resp_owner <= w_resp_owner_nxt;
    end
  end

  always_comb begin
    w_resp_owner_nxt = NONE;
    if (w_a_win && !bus.a_we) begin
      w_resp_owner_nxt = RESP_A;
    end else if (w_b_win && !bus.b_we) begin
      w_resp_owner_nxt = RESP_B;
    end
  end

  // Reset in the response cycle drops the pending response.
  assign bus.a_rvalid = (r_resp_owner == RESP_A) & ~rst;
  assign bus.b_rvalid = (r_resp_owner == RESP_B) & ~rst;
  assign bus.a_rdata  = bus.mem_rdata;
  assign bus.b_rdata  = bus.mem_rdata;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_starve;

  // Stall cycles on A and B grants forced by the starvation limit while A was asking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall  <= '0;
      r_perf_starve <= '0;
    end else begin
      if (w_a_stall) begin
        r_perf_stall <= r_perf_stall + 32'(1);
      end
      if (w_b_win && bus.a_req) begin
        r_perf_starve <= r_perf_starve + 32'(1);
      end
    end
  end

  assign perf_stall_cnt  = r_perf_stall;
  assign perf_starve_cnt = r_perf_starve;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: directed vectors push expectations, a negedge monitor checks.
module tb_dmem_port_arbiter;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_port_arbiter_if bus ();

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_starve_cnt;
`endif

  dmem_port_arbiter #(
    .MAX_WAIT (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus)
`ifdef DMEM_ARB_PERF_EN
    ,
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_starve_cnt (perf_starve_cnt)
`endif
  );

  // Single-port memory model: registered read of the presented address, old data on same-cycle write.
  logic [31:0] mem [256];
  logic        mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[16]    <= 32'hDEADBEEF;
      mem_loaded <= 1'b1;
    end else begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  typedef struct {
    logic        rst;
    logic        ar, aw;
    logic [7:0]  aa;
    logic [31:0] ad;
    logic        br, bw;
    logic [7:0]  ba;
    logic [31:0] bd;
    logic [3:0]  eg;    // {a_gnt, b_gnt, a_stall, mem_we}
    logic [1:0]  rvp;   // 0 none, 1 A, 2 B response next cycle
    logic [31:0] rvd;
  } vec_t;

  typedef struct {
    logic [1:0]  port;
    logic [31:0] data;
  } rv_t;

  vec_t       vq[$];
  logic [3:0] gq[$];
  rv_t        rq[$];
`ifdef DMEM_ARB_PERF_EN
  logic [63:0] pq[$];
`endif
  int   n_vec = 0;
  int   n_err = 0;
  logic done  = 1'b0;

  task automatic add(input logic r, input logic ar, input logic aw, input logic [7:0] aa,
                     input logic [31:0] ad, input logic br, input logic bw, input logic [7:0] ba,
                     input logic [31:0] bd, input logic [3:0] eg, input logic [1:0] rvp,
                     input logic [31:0] rvd);
    vec_t v;
    v.rst = r;  v.ar = ar; v.aw = aw; v.aa = aa; v.ad = ad;
    v.br  = br; v.bw = bw; v.ba = ba; v.bd = bd;
    v.eg  = eg; v.rvp = rvp; v.rvd = rvd;
    vq.push_back(v);
  endtask

  task automatic add_idle();
    add(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 4'b0000, 2'd0, 32'h0);
  endtask

  // A reads 0x10, B reads 0x20, both held: A wins four cycles, B the fifth.
  task automatic add_contention(input int n);
    for (int i = 0; i < n; i++) begin
      if (i % 5 == 4)
        add(1'b0, 1'b1, 1'b0, 8'h10, 32'h0, 1'b1, 1'b0, 8'h20, 32'h0, 4'b0110, 2'd2, 32'h12345678);
      else
        add(1'b0, 1'b1, 1'b0, 8'h10, 32'h0, 1'b1, 1'b0, 8'h20, 32'h0, 4'b1000, 2'd1, 32'hDEADBEEF);
    end
  endtask

  task automatic apply(input vec_t v);
    rv_t e;
    @(posedge clk);
    #1;
    rst         = v.rst;
    bus.a_req   = v.ar; bus.a_we = v.aw; bus.a_addr = v.aa; bus.a_wdata = v.ad;
    bus.b_req   = v.br; bus.b_we = v.bw; bus.b_addr = v.ba; bus.b_wdata = v.bd;
    gq.push_back(v.eg);
    if (v.rvp != 2'd0) begin
      e.port = v.rvp;
      e.data = v.rvd;
      rq.push_back(e);
    end
  endtask

  task automatic chk_rv(input logic [1:0] p, input logic [31:0] d);
    rv_t e;
    n_vec++;
    if (rq.size() == 0) begin
      n_err++;
      $display("FAIL rvalid: port %0d presented data %h, no response expected", p, d);
    end else begin
      e = rq.pop_front();
      if (e.port !== p || e.data !== d) begin
        n_err++;
        $display("FAIL rdata: got port %0d data %h, want port %0d data %h", p, d, e.port, e.data);
      end
    end
  endtask

  // Monitor: checks grant/stall/we each cycle, read responses as they appear, then drains.
  logic [3:0]  mon_g;
  logic [63:0] mon_p;
  always @(negedge clk) begin
    if (gq.size() > 0) begin
      mon_g = gq.pop_front();
      n_vec++;
      if ({bus.a_gnt, bus.b_gnt, bus.a_stall, bus.mem_we} !== mon_g) begin
        n_err++;
        $display("FAIL gnt: {a_gnt,b_gnt,a_stall,mem_we} got %b want %b",
                 {bus.a_gnt, bus.b_gnt, bus.a_stall, bus.mem_we}, mon_g);
      end
    end
    if (bus.a_rvalid) chk_rv(2'd1, bus.a_rdata);
    if (bus.b_rvalid) chk_rv(2'd2, bus.b_rdata);
`ifdef DMEM_ARB_PERF_EN
    if (pq.size() > 0) begin
      mon_p = pq.pop_front();
      n_vec++;
      if ({perf_stall_cnt, perf_starve_cnt} !== mon_p) begin
        n_err++;
        $display("FAIL perf: stall %0d starve %0d, want stall %0d starve %0d",
                 perf_stall_cnt, perf_starve_cnt, mon_p[63:32], mon_p[31:0]);
      end
    end
`endif
    if (done) begin
      n_vec++;
      if (rq.size() != 0) begin
        n_err++;
        $display("FAIL drain: %0d read responses never arrived, want 0", rq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    vec_t idle_v, rst_v;
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;

    // Reset with both requesting: no grants, A stalled.
    add(1'b1, 1'b1, 1'b0, 8'h10, 32'h0, 1'b1, 1'b0, 8'h20, 32'h0, 4'b0010, 2'd0, 32'h0);
    add(1'b1, 1'b1, 1'b0, 8'h10, 32'h0, 1'b1, 1'b0, 8'h20, 32'h0, 4'b0010, 2'd0, 32'h0);
    // A read only.
    add(1'b0, 1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 4'b1000, 2'd1, 32'hDEADBEEF);
    add_idle();
    // A writes 0x20, B reads it back next cycle.
    add(1'b0, 1'b1, 1'b1, 8'h20, 32'h12345678, 1'b0, 1'b0, 8'h00, 32'h0, 4'b1001, 2'd0, 32'h0);
    add(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h20, 32'h0, 4'b0100, 2'd2, 32'h12345678);
    // Read then write the same address back to back: read sees old data.
    add(1'b0, 1'b1, 1'b0, 8'h30, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 4'b1000, 2'd1, 32'h0);
    add(1'b0, 1'b1, 1'b1, 8'h30, 32'h0000CAFE, 1'b0, 1'b0, 8'h00, 32'h0, 4'b1001, 2'd0, 32'h0);
    add(1'b0, 1'b1, 1'b0, 8'h30, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 4'b1000, 2'd1, 32'h0000CAFE);
    add_idle();
    add_contention(10);
    // Both write 0x40 in consecutive grants; the later (B) wins.
    add(1'b0, 1'b1, 1'b1, 8'h40, 32'h111, 1'b1, 1'b1, 8'h40, 32'h222, 4'b1001, 2'd0, 32'h0);
    add(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 8'h40, 32'h222, 4'b0101, 2'd0, 32'h0);
    add(1'b0, 1'b1, 1'b0, 8'h40, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 4'b1000, 2'd1, 32'h222);
    add_idle();
    // B read granted, reset next cycle drops its response.
    add(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h10, 32'h0, 4'b0100, 2'd0, 32'h0);
    add(1'b1, 1'b1, 1'b0, 8'h10, 32'h0, 1'b1, 1'b0, 8'h20, 32'h0, 4'b0010, 2'd0, 32'h0);
    add_idle();
    // Partial contention, reset, then full contention: wait count must restart from 0.
    add(1'b0, 1'b1, 1'b0, 8'h10, 32'h0, 1'b1, 1'b0, 8'h20, 32'h0, 4'b1000, 2'd1, 32'hDEADBEEF);
    add(1'b0, 1'b1, 1'b0, 8'h10, 32'h0, 1'b1, 1'b0, 8'h20, 32'h0, 4'b1000, 2'd0, 32'h0);
    add(1'b1, 1'b1, 1'b0, 8'h10, 32'h0, 1'b1, 1'b0, 8'h20, 32'h0, 4'b0010, 2'd0, 32'h0);
    add_contention(10);
    add_idle();

    foreach (vq[i]) apply(vq[i]);

    idle_v = vq[vq.size() - 1];
    rst_v  = idle_v;
    rst_v.rst = 1'b1;
`ifdef DMEM_ARB_PERF_EN
    pq.push_back({32'd2, 32'd2});
    apply(rst_v);
    apply(idle_v);
    pq.push_back({32'd0, 32'd0});
`endif
    repeat (3) apply(idle_v);
    done = 1'b1;
  end

endmodule
